// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian 32-bit words and writes them to IMEM.
// Optional trailing checksum byte and error flag are compiled in with LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start after reset, CPU held
// RECV  | collecting the four bytes of the current word
// WRITE | one-cycle IMEM write of the assembled word
// CHECK | waiting for the trailing checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | load finished, CPU released until the next start
module imem_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic        error
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd3;
`endif
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  idx_q, idx_d;
  logic [1:0]  bidx_q, bidx_d;
  // only the first three bytes need storage; the fourth goes straight to imem_wdata
  logic [23:0] word_q, word_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
`endif

  assign xfer = byte_valid & byte_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d  = word_count;
          idx_d  = 10'd0;
          bidx_d = 2'd0;
          word_d = 24'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = 8'd0;
          err_d  = 1'b0;
          state_d = (word_count == 10'd0) ? CHECK : RECV;
`else
          state_d = (word_count == 10'd0) ? DONE : RECV;
`endif
        end
      end
      RECV: begin
        if (xfer) begin
          bidx_d = bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + byte_data;
`endif
          case (bidx_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              addr_d  = {52'd0, idx_q, 2'b00};
              wdata_d = {byte_data, word_q};
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        if (idx_q == cnt_q - 10'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          err_d   = (sum_q + byte_data) != 8'd0;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 10'd0;
      idx_q   <= 10'd0;
      bidx_q  <= 2'd0;
      word_q  <= 24'd0;
      addr_q  <= 64'd0;
      wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == RECV) || (state_q == CHECK);
  assign busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
  assign error      = err_q;
`else
  assign byte_ready = (state_q == RECV);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
`endif
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == DONE);
  assign cpu_hold   = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads checked against a byte-queue model of the expected writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  word_count = 10'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready, imem_we, cpu_hold, busy, done;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic        error;
  bit          exp_err;
`endif

  int total = 0;
  int bad = 0;

  logic [63:0] got_a[$];
  logic [31:0] got_d[$];
  bit   [7:0]  prog_q[$];
  bit   [7:0]  stim_q[$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .error(error)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (imem_we === 1'b1) begin
      got_a.push_back(imem_addr);
      got_d.push_back(imem_wdata);
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(int i);
    return {prog_q[4*i+3], prog_q[4*i+2], prog_q[4*i+1], prog_q[4*i]};
  endfunction

  task automatic finalize(input bit corrupt);
    stim_q = prog_q;
`ifdef LOADER_CHECKSUM_EN
    begin
      int sum;
      bit [7:0] ck;
      sum = 0;
      foreach (prog_q[k]) sum += int'(prog_q[k]);
      ck = 8'((256 - (sum % 256)) % 256);
      if (corrupt) ck = ck + 8'($urandom_range(1, 255));
      stim_q.push_back(ck);
      exp_err = ((sum + int'(ck)) % 256) != 0;
    end
`endif
  endtask

  task automatic prep_random(input int n, input bit corrupt);
    prog_q.delete();
    for (int k = 0; k < 4*n; k++) prog_q.push_back(8'($urandom_range(255)));
    finalize(corrupt);
  endtask

  task automatic start_load(input logic [9:0] n);
    got_a.delete();
    got_d.delete();
    @(negedge clk);
    word_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    word_count = 10'($urandom);
  endtask

  task automatic send_bytes(input int stall_pct, input int max_bytes, output bit ok);
    int guard;
    int sent;
    guard = 0;
    sent = 0;
    ok = 1'b1;
    while (stim_q.size() > 0 && sent < max_bytes) begin
      bit take;
      if (guard >= 20000) begin
        ok = 1'b0;
        break;
      end
      if ($urandom_range(99) < stall_pct) begin
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data = stim_q[0];
      end
      take = byte_valid && (byte_ready === 1'b1);
      @(negedge clk);
      if (take) begin
        void'(stim_q.pop_front());
        sent++;
      end
      guard++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (imem_we !== 1'b0)     begin bad++; $display("FAIL rst_we got=%b exp=0", imem_we); end
    total++; if (byte_ready !== 1'b0)  begin bad++; $display("FAIL rst_ready got=%b exp=0", byte_ready); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (cpu_hold !== 1'b1)    begin bad++; $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
    total++; if (imem_addr !== 64'd0)  begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (imem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
`ifdef LOADER_CHECKSUM_EN
    total++; if (error !== 1'b0)       begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_two_words;
    bit ok1, ok2;
    prog_q = '{8'h6F, 8'hF9, 8'h01, 8'h91, 8'h00, 8'h00, 8'h00, 8'h14};
    finalize(1'b0);
    start_load(10'd2);
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL two_timeout got=%b%b exp=11", ok1, ok2); end
    total++;
    if (got_a.size() !== 2) begin
      bad++; $display("FAIL two_count got=%0d exp=2", got_a.size());
    end else if (got_a[0] !== 64'd0 || got_d[0] !== 32'h9101F96F ||
                 got_a[1] !== 64'd4 || got_d[1] !== 32'h14000000) begin
      bad++; $display("FAIL two_writes got=%h:%h %h:%h exp=0:9101f96f 4:14000000",
                      got_a[0], got_d[0], got_a[1], got_d[1]);
    end
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL two_final got=done%b hold%b busy%b exp=done1 hold0 busy0", done, cpu_hold, busy);
    end
`ifdef LOADER_CHECKSUM_EN
    total++; if (error !== 1'b0) begin bad++; $display("FAIL two_error got=%b exp=0", error); end
`endif
  endtask

  task automatic test_reset_mid;
    bit ok1, ok2;
    prep_random(1, 1'b0);
    start_load(10'd1);
    send_bytes(0, 3, ok1);
    #2 reset = 1'b0;
    #1;
    total++; if (imem_we !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++; $display("FAIL midrst_ctrl got=we%b rdy%b busy%b done%b hold%b exp=we0 rdy0 busy0 done0 hold1",
                      imem_we, byte_ready, busy, done, cpu_hold);
    end
    total++; if (imem_addr !== 64'd0 || imem_wdata !== 32'd0) begin
      bad++; $display("FAIL midrst_data got=%h:%h exp=0:0", imem_addr, imem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    total++; if (got_a.size() !== 0) begin bad++; $display("FAIL midrst_nowrite got=%0d exp=0", got_a.size()); end
    prep_random(1, 1'b0);
    start_load(10'd1);
    send_bytes(20, 1 << 30, ok1);
    wait_done(ok2);
    total++; if (!(ok1 && ok2) || got_a.size() !== 1) begin
      bad++; $display("FAIL midrst_reload got=%0d writes exp=1", got_a.size());
    end else if (got_a[0] !== 64'd0 || got_d[0] !== model_word(0)) begin
      bad++; $display("FAIL midrst_reload got=%h:%h exp=0:%h", got_a[0], got_d[0], model_word(0));
    end
  endtask

  task automatic test_stall;
    bit ok1, ok2, stall_bad;
    prep_random(1, 1'b0);
    start_load(10'd1);
    send_bytes(0, 2, ok1);
    stall_bad = 1'b0;
    repeat (10) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom);
      @(negedge clk);
      if (imem_we !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) stall_bad = 1'b1;
    end
    total++; if (stall_bad || got_a.size() !== 0) begin
      bad++; $display("FAIL stall_hold got=flag%b writes%0d exp=flag0 writes0", stall_bad, got_a.size());
    end
    send_bytes(0, 1 << 30, ok2);
    wait_done(ok1);
    total++; if (!ok1 || got_a.size() !== 1) begin
      bad++; $display("FAIL stall_write got=%0d writes exp=1", got_a.size());
    end else if (got_a[0] !== 64'd0 || got_d[0] !== model_word(0)) begin
      bad++; $display("FAIL stall_word got=%h:%h exp=0:%h", got_a[0], got_d[0], model_word(0));
    end
  endtask

  task automatic test_zero;
    bit ok1, ok2;
    prog_q.delete();
    finalize(1'b0);
    start_load(10'd0);
`ifdef LOADER_CHECKSUM_EN
    total++; if (done !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL zero_check got=done%b rdy%b busy%b exp=done0 rdy1 busy1", done, byte_ready, busy);
    end
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
    total++; if (!ok2 || error !== 1'b0) begin bad++; $display("FAIL zero_done got=done%b err%b exp=done1 err0", done, error); end
`else
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      bad++; $display("FAIL zero_done got=done%b hold%b exp=done1 hold0", done, cpu_hold);
    end
`endif
    total++; if (got_a.size() !== 0) begin bad++; $display("FAIL zero_nowrite got=%0d exp=0", got_a.size()); end
  endtask

  task automatic test_start_ignored;
    bit ok1, ok2;
    int errs;
    prep_random(2, 1'b0);
    start_load(10'd2);
    send_bytes(0, 2, ok1);
    @(negedge clk);
    word_count = 10'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bytes(10, 5, ok1);
    start = 1'b1;
    word_count = 10'd3;
    @(negedge clk);
    start = 1'b0;
    send_bytes(10, 1 << 30, ok1);
    wait_done(ok2);
    errs = 0;
    if (got_a.size() == 2) begin
      for (int i = 0; i < 2; i++) if (got_a[i] !== 64'(4*i) || got_d[i] !== model_word(i)) errs++;
    end
    total++; if (!(ok1 && ok2) || got_a.size() !== 2 || errs != 0) begin
      bad++; $display("FAIL start_ignored got=%0d writes %0d bad exp=2 writes 0 bad", got_a.size(), errs);
    end
  endtask

  task automatic test_restart;
    bit ok1, ok2;
    prep_random(1, 1'b0);
    start_load(10'd1);
    total++; if (cpu_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL restart_flags got=hold%b busy%b done%b exp=hold1 busy1 done0", cpu_hold, busy, done);
    end
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
    total++; if (!(ok1 && ok2) || got_a.size() !== 1) begin
      bad++; $display("FAIL restart_write got=%0d writes exp=1", got_a.size());
    end else if (got_a[0] !== 64'd0 || got_d[0] !== model_word(0)) begin
      bad++; $display("FAIL restart_word got=%h:%h exp=0:%h", got_a[0], got_d[0], model_word(0));
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      bit ok1, ok2;
      int n, errs;
      n = $urandom_range(1, 6);
      prep_random(n, 1'($urandom_range(1)));
      start_load(10'(n));
      send_bytes(30, 1 << 30, ok1);
      wait_done(ok2);
      errs = 0;
      if (got_a.size() == n) begin
        for (int i = 0; i < n; i++) if (got_a[i] !== 64'(4*i) || got_d[i] !== model_word(i)) errs++;
      end
      total++; if (!(ok1 && ok2) || got_a.size() !== n || errs != 0) begin
        bad++; $display("FAIL random_%0d got=%0d writes %0d bad exp=%0d writes 0 bad", r, got_a.size(), errs, n);
      end
`ifdef LOADER_CHECKSUM_EN
      total++; if (error !== exp_err) begin bad++; $display("FAIL random_err_%0d got=%b exp=%b", r, error, exp_err); end
`endif
    end
  endtask

  task automatic test_max;
    bit ok1, ok2;
    int errs;
    prep_random(1023, 1'b0);
    start_load(10'd1023);
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
    errs = 0;
    if (got_a.size() == 1023) begin
      for (int i = 0; i < 1023; i++) if (got_a[i] !== 64'(4*i) || got_d[i] !== model_word(i)) errs++;
    end
    total++; if (!(ok1 && ok2) || got_a.size() !== 1023 || errs != 0) begin
      bad++; $display("FAIL max_load got=%0d writes %0d bad exp=1023 writes 0 bad", got_a.size(), errs);
    end
    total++; if (imem_addr !== 64'd4088) begin bad++; $display("FAIL max_addr got=%0d exp=4088", imem_addr); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bit ok1, ok2;
    prog_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    stim_q = prog_q;
    stim_q.push_back(8'hF6);
    start_load(10'd1);
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
    total++; if (!ok2 || error !== 1'b0) begin bad++; $display("FAIL ck_good got=done%b err%b exp=done1 err0", done, error); end
    stim_q = prog_q;
    stim_q.push_back(8'hF7);
    start_load(10'd1);
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
    total++; if (!ok2 || error !== 1'b1 || got_a.size() !== 1 || got_d[0] !== 32'h04030201) begin
      bad++; $display("FAIL ck_bad got=done%b err%b writes%0d exp=done1 err1 writes1", done, error, got_a.size());
    end
    prep_random(1, 1'b0);
    start_load(10'd1);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL ck_clear got=%b exp=0", error); end
    send_bytes(0, 1 << 30, ok1);
    wait_done(ok2);
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_reset_mid();
    test_stall();
    test_zero();
    test_start_ignored();
    test_restart();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have these ports, with widths and meanings as listed:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- word_count  in  10  number of 32-bit words to load; latched on an accepted start.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  64  byte address of the write; always a multiple of 4.
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  holds the CPU program counter in reset.
- busy  out  1  load in progress.
- done  out  1  load complete.
- error  out  1  checksum mismatch (exists only with LOADER_CHECKSUM_EN).
REQ-002 The design SHALL use one clock domain; reset is asynchronous and active-low.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, RECV, WRITE, CHECK and DONE; CHECK SHALL exist only when checksum is compiled in.
REQ-004 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both 1; byte_ready SHALL be 1 only in RECV and CHECK.
REQ-005 Word assembly SHALL be little-endian: the first byte of a word goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-006 IDLE/DONE with start=1 SHALL latch word_count, clear the word index and byte index, and go to RECV; if word_count=0, it SHALL go directly to CHECK (enabled) or DONE (disabled).
REQ-007 RECV SHALL go to WRITE on the cycle the fourth byte of a word transfers.
REQ-008 WRITE SHALL last exactly one cycle, with:
- imem_we=1
- imem_addr = word_index*4
- imem_wdata = the assembled word
REQ-009 The exit from WRITE SHALL depend on the word just written:
- if it is the last word (word_index = word_count-1), go to CHECK (enabled) or DONE (disabled);
- otherwise increment word_index and return to RECV.
REQ-010 imem_we SHALL be 0 in every state except WRITE; imem_addr and imem_wdata SHALL hold their last values outside WRITE.
REQ-011 start SHALL be ignored in RECV, WRITE and CHECK.
REQ-012 cpu_hold SHALL be 1 in every state except DONE.
REQ-013 busy SHALL be 1 in RECV, WRITE and CHECK.
REQ-014 done SHALL be 1 only in DONE.
REQ-015 DONE SHALL persist until an accepted start; a restart SHALL reassert cpu_hold on the next cycle.
REQ-016 Stalls of byte_valid SHALL be tolerated indefinitely with no state change.
REQ-017 The maximum load SHALL be 1023 words, giving a top address of 64'd4088.

Reset
REQ-018 reset=0 SHALL immediately force the following, regardless of the cycle:
- state = IDLE, all counters = 0, assembled word = 0, running checksum = 0;
- imem_we=0, byte_ready=0, busy=0, done=0, error=0, cpu_hold=1, imem_addr=0, imem_wdata=0.
REQ-019 A reset in the middle of a word or a load SHALL abandon the partial word with no write, and the next load SHALL restart at address 0.

Configuration
REQ-020 The checksum feature SHALL be compiled in when the macro LOADER_CHECKSUM_EN is defined.
REQ-021 With LOADER_CHECKSUM_EN defined:
- the loader keeps an 8-bit running sum (mod 256) of all program bytes;
- CHECK accepts one trailing checksum byte, then goes to DONE;
- error is set in DONE when (sum + checksum byte) mod 256 != 0, and is cleared on an accepted start;
- words are still written when error is set.
REQ-022 Without LOADER_CHECKSUM_EN:
- the CHECK state, the running sum and the error port are absent;
- the last WRITE goes directly to DONE.

Verification
REQ-023 Load of 2 words: start with word_count=2, then bytes 6F,F9,01,91, 00,00,00,14 -> two WRITE pulses:
- addr 0, data 32'h9101F96F;
- addr 4, data 32'h14000000;
- then done=1, cpu_hold=0.
REQ-024 Stalled byte stream: byte_valid low for 10 cycles between bytes 2 and 3 -> no imem_we during the stall; the assembled word is unchanged and correct.
REQ-025 start with word_count=0 -> done=1 one cycle after start (checksum disabled), with no imem_we pulse.
REQ-026 Reset mid-load: reset driven low after 3 of 4 bytes -> no write occurs; outputs hold reset values; a fresh load of 1 word writes to addr 0.
REQ-027 Checksum (with LOADER_CHECKSUM_EN): one word with bytes 01,02,03,04 and checksum byte F6 -> error=0; the same with checksum byte F7 -> error=1 and done=1.
REQ-028 Restart from DONE: start in DONE -> cpu_hold=1 and busy=1 on the next cycle, and a new load begins at addr 0.
